// File: rtl/pixel_fetch_pkg.sv
// Shared types and defaults for the pixel fetch block: FSM state encoding,
// width defaults and the packed pixel-buffer entry.
package pixel_fetch_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 32;
  localparam int DIM_W_DEF      = 10;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // One buffered pixel: data plus the end-of-frame marker.
  typedef struct packed {
    logic                  last;
    logic [DATA_W_DEF-1:0] data;
  } pix_entry_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pixel_fetch_if.sv
// Single-word read port between pixel_fetch (master) and the SRAM/bus (slave).
// Returns are in order; mem_gnt accepts the request presented that cycle.
interface pixel_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/pixel_fetch_checker.sv
// Invariant checks for the credit scheme: the buffer can never overflow and
// reads in flight plus buffered pixels never exceed the buffer depth.
module pixel_fetch_checker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic             full,
  input logic [CNT_W-1:0] outstanding,
  input logic [CNT_W-1:0] count
);

  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

  credit_bound: assert property (@(posedge clk) disable iff (rst)
    (int'(outstanding) + int'(count)) <= DEPTH);

endmodule

// File: rtl/pixel_fetch_fetch_fifo.sv
// Small synchronous FIFO with registered storage and a combinational head.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write; contents need no reset because empty gates the head.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/pixel_fetch.sv
// Frame walker in front of addr_calc: steps row/col, issues one read per
// pixel address while credit allows, and buffers in-order returns for the
// filter datapath.
module pixel_fetch
  import pixel_fetch_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DIM_W      = DIM_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  input  logic [ADDR_W-1:0] calc_addr,
  output logic              init,
  output logic              addr_calc_en,
  output logic              addr_done,
  output logic              new_row,
  output logic [DIM_W-1:0]  row_cnt,
  output logic [DIM_W-1:0]  col_cnt,
  pixel_fetch_if.master     mem,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_last,
  input  logic              pix_ready,
  output logic              frame_done,
  output logic              err
);
  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  state_t           state_r, next_s;
  logic [DIM_W-1:0] width_r, height_r, row_r, col_r;
  logic [CNT_W-1:0] outstanding_r, fifo_count_s;
  logic             err_r, frame_done_r;
  logic             credit_s, accept_s, last_col_s, last_pix_s, start_ok_s;
  logic             ret_ok_s, stray_s, push_s, pop_s;
  logic             fifo_full_s, fifo_empty_s;
  pix_entry_t       wr_entry_s, head_s;

  assign start_ok_s = (img_width != DIM_W'(0)) && (img_height != DIM_W'(0));
  assign last_col_s = (col_r == width_r - DIM_W'(1));
  assign last_pix_s = last_col_s && (row_r == height_r - DIM_W'(1));
  assign credit_s   = ({1'b0, outstanding_r} + {1'b0, fifo_count_s}) < (CNT_W+1)'(FIFO_DEPTH);
  assign accept_s   = (state_r == ISSUE) && credit_s && mem.mem_gnt;
  assign ret_ok_s   = mem.mem_rvalid && (outstanding_r != CNT_W'(0));
  assign stray_s    = mem.mem_rvalid && (outstanding_r == CNT_W'(0));

  // Returns are in order and no request is issued after the final one, so
  // the final return is the one that empties the in-flight count in DRAIN.
  assign push_s          = ret_ok_s;
  assign wr_entry_s.last = (state_r == DRAIN) && (outstanding_r == CNT_W'(1));
  assign wr_entry_s.data = mem.mem_rdata;
  assign pop_s           = pix_valid && pix_ready;

  assign mem.mem_addr = calc_addr;
  assign addr_done    = accept_s;
  assign new_row      = accept_s && last_col_s;
  assign row_cnt      = row_r;
  assign col_cnt      = col_r;
  assign pix_valid    = !fifo_empty_s;
  assign pix_data     = fifo_empty_s ? DATA_W'(0) : head_s.data;
  assign pix_last     = !fifo_empty_s && head_s.last;
  assign frame_done   = frame_done_r;
  assign err          = err_r;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    next_s       = state_r;
    init         = 1'b0;
    addr_calc_en = 1'b0;
    mem.mem_req  = 1'b0;
    case (state_r)
      IDLE: begin
        if (fetch_start) begin
          if (start_ok_s) begin
            next_s = INIT;
          end else begin
            next_s = DONE;
          end
        end else begin
          next_s = IDLE;
        end
      end
      INIT: begin
        init   = 1'b1;
        next_s = ISSUE;
      end
      ISSUE: begin
        addr_calc_en = 1'b1;
        mem.mem_req  = credit_s;
        if (accept_s && last_pix_s) begin
          next_s = DRAIN;
        end else begin
          next_s = ISSUE;
        end
      end
      DRAIN: begin
        if ((outstanding_r == CNT_W'(0)) && fifo_empty_s) begin
          next_s = DONE;
        end else begin
          next_s = DRAIN;
        end
      end
      DONE: begin
        next_s = IDLE;
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // Frame dimensions latched at start; row/col advance on each accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_r  <= '0;
      height_r <= '0;
      row_r    <= '0;
      col_r    <= '0;
    end else if ((state_r == IDLE) && fetch_start && start_ok_s) begin
      width_r  <= img_width;
      height_r <= img_height;
      row_r    <= '0;
      col_r    <= '0;
    end else if (accept_s) begin
      if (last_col_s) begin
        col_r <= '0;
        row_r <= row_r + DIM_W'(1);
      end else begin
        col_r <= col_r + DIM_W'(1);
      end
    end else begin
      row_r <= row_r;
      col_r <= col_r;
    end
  end

  // Reads in flight: +1 on accept, -1 on a matched return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_r <= '0;
    end else begin
      case ({accept_s, ret_ok_s})
        2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
        2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Sticky stray-return flag and the registered end-of-frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r        <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      err_r        <= err_r || stray_s;
      frame_done_r <= (state_r == DONE);
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pix_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (wr_entry_s),
    .pop   (pop_s),
    .rdata (head_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  pixel_fetch_checker #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .push        (push_s),
    .full        (fifo_full_s),
    .outstanding (outstanding_r),
    .count       (fifo_count_s)
  );

endmodule

// File: tb/tb_pixel_fetch.sv
// Self-checking bench for pixel_fetch: a table of frames plus random frames
// checked cycle by cycle against a queue-based model of the frame walk,
// credit limit, in-order memory and pixel buffer; hand sequences cover the
// credit stall and reset with reads in flight.
module tb_pixel_fetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_start = 1'b0;
  logic [9:0]  img_width = '0, img_height = '0;
  logic [31:0] calc_addr = '0;
  logic        init, addr_calc_en, addr_done, new_row;
  logic [9:0]  row_cnt, col_cnt;
  logic        pix_valid, pix_last, frame_done, err;
  logic [31:0] pix_data;
  logic        pix_ready = 1'b0;

  pixel_fetch_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  pixel_fetch dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .img_width(img_width),
    .img_height(img_height), .calc_addr(calc_addr), .init(init),
    .addr_calc_en(addr_calc_en), .addr_done(addr_done), .new_row(new_row),
    .row_cnt(row_cnt), .col_cnt(col_cnt), .mem(mem_bus), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_last(pix_last), .pix_ready(pix_ready),
    .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w; int h; int gnt_mode; int ready_mode; int lat; int repulse;
    int exp_reads; int exp_pix;
  } vec_t;

  int checks = 0, errors = 0;
  int cyc = 0;
  int gnt_mode, ready_mode, lat, repulse;
  int fs_pend = 0, fs_w, fs_h;
  bit active = 0;
  int start_cyc, n_total, w_m, idx, ret_idx, acc_cyc, last_ret, fd_expect = -1;
  int acc_cnt, pix_cnt, fd_cnt;
  logic [31:0] base;
  int          ret_due[$];
  logic [31:0] ret_addr[$];
  logic [32:0] fifo_m[$];

  function automatic logic [31:0] rd(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h00C0FFEE;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic step();
    bit g, exp_en, exp_req, exp_init, nr, drain_ok;
    int in_fl, occ, due;
    logic [32:0] ent;
    case (gnt_mode)
      0:       g = 1'b1;
      1:       g = (cyc % 2 == 0);
      default: g = 1'($urandom_range(0, 1));
    endcase
    mem_bus.mem_gnt = g;
    if (ret_due.size() > 0 && ret_due[0] == cyc) begin
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = rd(ret_addr[0]);
    end else begin
      mem_bus.mem_rvalid = 1'b0;
      mem_bus.mem_rdata  = $urandom;
    end
    calc_addr = base + 32'(idx);
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = 1'($urandom_range(0, 1));
      default: pix_ready = 1'b0;
    endcase
    if (fs_pend != 0) begin
      fetch_start = 1'b1; img_width = 10'(fs_w); img_height = 10'(fs_h); fs_pend = 0;
    end else begin
      fetch_start = (repulse != 0) && active && (cyc == start_cyc + 3);
      img_width = 10'($urandom_range(0, 9)); img_height = 10'($urandom_range(0, 9));
    end
    #2;
    in_fl    = ret_due.size();
    occ      = fifo_m.size();
    exp_en   = active && n_total > 0 && cyc >= start_cyc + 2 && idx < n_total;
    exp_req  = exp_en && (in_fl + occ < DEPTH);
    exp_init = active && n_total > 0 && cyc == start_cyc + 1;
    nr = 1'b0;
    if (exp_req && g) nr = (idx % w_m == w_m - 1);
    chk("mem_req", 64'(mem_bus.mem_req), 64'(exp_req));
    chk("init", 64'(init), 64'(exp_init));
    chk("addr_calc_en", 64'(addr_calc_en), 64'(exp_en));
    chk("addr_done", 64'(addr_done), 64'(exp_req && g));
    chk("new_row", 64'(new_row), 64'(nr));
    if (exp_req) chk("mem_addr", 64'(mem_bus.mem_addr), 64'(base + 32'(idx)));
    if (exp_en) begin
      chk("row_cnt", 64'(row_cnt), 64'(idx / w_m));
      chk("col_cnt", 64'(col_cnt), 64'(idx % w_m));
    end
    chk("pix_valid", 64'(pix_valid), 64'(occ > 0));
    if (occ > 0) begin
      chk("pix_data", 64'(pix_data), 64'(fifo_m[0][31:0]));
      chk("pix_last", 64'(pix_last), 64'(fifo_m[0][32]));
    end
    chk("frame_done", 64'(frame_done), 64'(cyc == fd_expect));
    chk("err", 64'(err), 64'(0));
    // model update for the coming edge
    if (frame_done === 1'b1) fd_cnt++;
    drain_ok = active && n_total > 0 && idx == n_total && cyc > acc_cyc &&
               in_fl == 0 && occ == 0 && fd_expect < 0;
    if (drain_ok) fd_expect = cyc + 2;
    if (occ > 0 && pix_ready) begin
      void'(fifo_m.pop_front());
      pix_cnt++;
    end
    if (mem_bus.mem_rvalid) begin
      ent = {ret_idx == n_total - 1, rd(ret_addr[0])};
      void'(ret_due.pop_front());
      void'(ret_addr.pop_front());
      ret_idx++;
      fifo_m.push_back(ent);
    end
    if (exp_req && g) begin
      due = cyc + lat;
      if (due <= last_ret) due = last_ret + 1;
      last_ret = due;
      ret_due.push_back(due);
      ret_addr.push_back(base + 32'(idx));
      if (idx == n_total - 1) acc_cyc = cyc;
      idx++;
      acc_cnt++;
    end
    if (active && cyc == fd_expect) active = 0;
    if (fetch_start && !active) begin
      active = 1; start_cyc = cyc; idx = 0; ret_idx = 0; acc_cyc = 0; last_ret = -1;
      acc_cnt = 0; pix_cnt = 0; fd_cnt = 0; w_m = int'(img_width);
      n_total = (img_width != 0 && img_height != 0) ? int'(img_width) * int'(img_height) : 0;
      fd_expect = (n_total == 0) ? cyc + 2 : -1;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic finish_frame();
    int n = 0;
    while (active && n < 3000) begin step(); n++; end
    if (active) begin
      errors++; checks++;
      $display("FAIL frame_timeout: frame still active after %0d cycles", n);
      active = 0;
    end
    repeat (2) step();
  endtask

  task automatic run_frame(input vec_t v, input logic [31:0] b);
    gnt_mode = v.gnt_mode; ready_mode = v.ready_mode; lat = v.lat; repulse = v.repulse;
    base = b; fs_w = v.w; fs_h = v.h; fs_pend = 1;
    step();
    finish_frame();
    chk("reads_accepted", 64'(acc_cnt), 64'(v.exp_reads));
    chk("pixels_delivered", 64'(pix_cnt), 64'(v.exp_pix));
    chk("frame_done_count", 64'(fd_cnt), 64'(1));
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    tbl[0] = '{2, 2, 0, 0, 1, 0, 4, 4};
    tbl[1] = '{3, 2, 1, 0, 1, 0, 6, 6};
    tbl[2] = '{0, 5, 0, 0, 1, 0, 0, 0};
    tbl[3] = '{4, 0, 0, 0, 1, 0, 0, 0};
    tbl[4] = '{3, 3, 0, 1, 2, 1, 9, 9};
    tbl[5] = '{1, 1, 0, 0, 1, 0, 1, 1};
    tbl[6] = '{5, 2, 2, 1, 3, 0, 10, 10};
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
    gnt_mode = 0; ready_mode = 0; lat = 1; repulse = 0; base = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_req", 64'(mem_bus.mem_req), 64'(0));
    chk("reset_pix_valid", 64'(pix_valid), 64'(0));
    chk("reset_row_col", 64'({row_cnt, col_cnt}), 64'(0));
    chk("reset_flags", 64'({init, addr_calc_en, frame_done, err}), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_frame(tbl[i], 32'd100 + 32'(i) * 32'd1000);

    // Credit stall: nothing popped, so only DEPTH reads may be accepted.
    gnt_mode = 0; ready_mode = 3; lat = 1; repulse = 0;
    base = 32'd9000; fs_w = 6; fs_h = 1; fs_pend = 1;
    repeat (14) step();
    chk("credit_accepts", 64'(acc_cnt), 64'(4));
    chk("credit_req_low", 64'(mem_bus.mem_req), 64'(0));
    ready_mode = 0;
    finish_frame();
    chk("credit_reads_total", 64'(acc_cnt), 64'(6));
    chk("credit_pixels_total", 64'(pix_cnt), 64'(6));
    chk("credit_frame_done", 64'(fd_cnt), 64'(1));

    for (int i = 0; i < 8; i++) begin
      rv.w = $urandom_range(1, 5); rv.h = $urandom_range(1, 4);
      rv.gnt_mode = 2; rv.ready_mode = 1; rv.lat = $urandom_range(1, 4);
      rv.repulse = $urandom_range(0, 1);
      rv.exp_reads = rv.w * rv.h; rv.exp_pix = rv.w * rv.h;
      run_frame(rv, $urandom);
    end

    // Reset with two reads in flight; their late returns are stray.
    gnt_mode = 0; ready_mode = 0; lat = 6; repulse = 0;
    base = 32'd500; fs_w = 4; fs_h = 1; fs_pend = 1;
    for (int n = 0; n < 20 && idx < 2; n++) step();
    chk("rst_inflight", 64'(ret_due.size()), 64'(2));
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mem_req", 64'(mem_bus.mem_req), 64'(0));
    chk("rst_row_col", 64'({row_cnt, col_cnt}), 64'(0));
    chk("rst_flags", 64'({init, addr_calc_en, addr_done, new_row, frame_done, err}), 64'(0));
    chk("rst_pix", 64'({pix_valid, pix_last, pix_data}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    active = 0; ret_due.delete(); ret_addr.delete(); fifo_m.delete(); fd_expect = -1;
    @(posedge clk); #1;
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_bus.mem_rvalid = 1'b0;
    #1;
    chk("stray_err", 64'(err), 64'(1));
    chk("stray_no_push", 64'(pix_valid), 64'(0));
    chk("stray_no_req", 64'(mem_bus.mem_req), 64'(0));
    @(posedge clk); #1;
    chk("stray_err_sticky", 64'(err), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("err_cleared", 64'(err), 64'(0));

    // A clean frame after the reset still behaves normally.
    run_frame(tbl[0], 32'd700);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_fetch.md
Name: pixel_fetch

Overview:
- Downstream consumer of addr_calc: walks an image row by row and drives addr_calc's control inputs (init, addr_calc_en, row_cnt, col_cnt, new_row, addr_done).
- Takes each calc_addr, issues a single-word read to the SRAM/bus read port, and buffers returned pixels in a small FIFO for the filter datapath.
- Credit-based: never has more reads in flight than free FIFO slots.

Parameters:
- DATA_W, 32, pixel/read-data width
- ADDR_W, 32, address width (matches calc_addr)
- DIM_W, 10, width of row/col counters and image dimensions
- FIFO_DEPTH, 4, pixel buffer depth (power of 2, >=2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- fetch_start  in  1  one-cycle pulse: begin frame
- img_width  in  DIM_W  pixels per row, sampled on fetch_start
- img_height  in  DIM_W  rows per frame, sampled on fetch_start
- calc_addr  in  ADDR_W  current pixel address from addr_calc
- init  out  1  one-cycle pulse: addr_calc loads start address
- addr_calc_en  out  1  high while frame addresses are being consumed
- addr_done  out  1  pulse: current calc_addr accepted by memory
- new_row  out  1  pulse coincident with addr_done on last column of a row
- row_cnt  out  DIM_W  current row index
- col_cnt  out  DIM_W  current column index
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  read address (= calc_addr)
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid, in-order
- mem_rdata  in  DATA_W  read data
- pix_valid  out  1  FIFO non-empty
- pix_data  out  DATA_W  FIFO head data
- pix_last  out  1  FIFO head is final pixel of frame
- pix_ready  in  1  consumer pops when pix_valid & pix_ready
- frame_done  out  1  one-cycle pulse: frame fully delivered
- err  out  1  sticky: mem_rvalid with nothing outstanding

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; outstanding=0; err=0.
- States: IDLE, INIT, ISSUE, DRAIN, DONE.
- IDLE:
  - fetch_start with width>0 and height>0: latch dims, row=col=0, -> INIT.
  - fetch_start with either dim 0: -> DONE, so frame_done pulses 2 cycles after start and no reads are issued.
- INIT: init=1 for exactly one cycle; -> ISSUE.
- ISSUE:
  - addr_calc_en=1.
  - credit = (outstanding + fifo_count) < FIFO_DEPTH.
  - mem_req = credit (combinational); mem_addr=calc_addr.
  - On mem_req & mem_gnt: addr_done=1 that cycle; outstanding++ (unless a return arrives the same cycle); column advances next edge.
  - col==width-1: col<=0, row++, new_row=1 with addr_done.
  - Accept of (height-1, width-1): -> DRAIN; that request is tagged last.
- DRAIN: addr_calc_en=0, mem_req=0; when outstanding==0 and FIFO empty -> DONE.
- DONE: frame_done=1 one cycle; -> IDLE.
- Returns: mem_rvalid with outstanding>0 pushes {last_tag, mem_rdata}. The last tag is set on the return matching the final accepted request (tracked by count).
- Stray return: mem_rvalid with outstanding==0 sets err and pushes nothing.
- Simultaneous push and pop in one cycle: count unchanged. Overflow cannot occur by construction; an assertion checks it.
- fetch_start while not IDLE is ignored; dims are not re-sampled.
- rst mid-frame: immediate return to reset values. In-flight returns after reset are stray (set err).
- Latency: first mem_req 2 cycles after fetch_start (INIT, then ISSUE). Pixel reaches pix_valid 1 cycle after its mem_rvalid.

Decomposition:
- Package pixel_fetch_pkg: state enum type, DIM_W/ADDR_W/DATA_W defaults, FIFO entry struct {last, data}.
- Sub-module fetch_fifo: synchronous FIFO with push/pop/count/full/empty, parameterised depth and width.

Test Plan:
- Reset then 2x2 frame, mem_gnt=1, rvalid 1 cycle after gnt, calc_addr=100,101,102,103, pix_ready=1 -> mem_addr 100..103 on consecutive cycles; new_row with 2nd and 4th addr_done; pix_data in order; pix_last only on 4th; frame_done once.
- 1x6 frame, pix_ready=0, rvalid always -> exactly 4 requests accepted, then mem_req low. Raise pix_ready -> remaining 2 issued, 6 pixels delivered in order.
- mem_gnt toggling 1,0,1,0 -> addr_done and col_cnt advance only on granted cycles; calc_addr held is re-presented.
- fetch_start with img_width=0 -> no mem_req, no init; frame_done exactly 2 cycles after start.
- rst asserted mid-frame with 2 outstanding, then 2 rvalids -> outputs zero during reset; err=1 after the stray returns; FIFO stays empty.
- fetch_start pulsed during ISSUE -> ignored; row/col sequence and frame_done count unchanged.
